dmi_cmd_bridge: RTL

Buffered, flow-controlled bridge between a host-side debug command port (JTAG or UART debug transport) and the core's DMI request/response interface (`debug_clockeddmi_*`), which the core shells currently tie off. It queues host DMI commands, issues them one at a time to the debug module, and queues the responses for the host. It also rejects reserved opcodes locally and, optionally, recovers from a debug module that never answers.

---
 rtl/dmi_cmd_bridge.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dmi_cmd_bridge.sv
// dmi_cmd_bridge: queued host-to-DMI command bridge; rejects reserved ops locally; DMI_TIMEOUT_EN adds a WAIT timeout
module dmi_cmd_bridge #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_data,
    input  logic [1:0]        host_req_op,
    output logic              host_resp_valid,
    input  logic              host_resp_ready,
    output logic [DATA_W-1:0] host_resp_data,
    output logic [1:0]        host_resp_resp,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic [ADDR_W-1:0] dmi_req_addr,
    output logic [DATA_W-1:0] dmi_req_data,
    output logic [1:0]        dmi_req_op,
    input  logic              dmi_resp_valid,
    output logic              dmi_resp_ready,
    input  logic [DATA_W-1:0] dmi_resp_data,
    input  logic [1:0]        dmi_resp_resp,
    output logic              busy,
    output logic              timeout_err,
    input  logic              timeout_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REJ} state_e;
    state_e state_q, state_d;

    logic [ADDR_W-1:0] cf_addr_q [DEPTH];
    logic [DATA_W-1:0] cf_data_q [DEPTH];
    logic [1:0]        cf_op_q   [DEPTH];
    logic [DATA_W-1:0] rf_data_q [DEPTH];
    logic [1:0]        rf_resp_q [DEPTH];
    logic [AW-1:0]     cf_wp_q, cf_rp_q, rf_wp_q, rf_rp_q;
    logic [AW:0]       cf_cnt_q, rf_cnt_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;
    logic [1:0]        req_op_q;
    logic [DATA_W-1:0] rf_data_d;
    logic [1:0]        rf_resp_d;
    logic              cf_push, cf_pop, rf_push, rf_pop, tmo;

    assign host_req_ready  = cf_cnt_q != FULL;
    assign host_resp_valid = rf_cnt_q != '0;
    assign host_resp_data  = rf_data_q[rf_rp_q];
    assign host_resp_resp  = rf_resp_q[rf_rp_q];
    assign cf_push         = host_req_valid && host_req_ready;
    assign rf_pop          = host_resp_valid && host_resp_ready;
    assign dmi_req_valid   = state_q == ISSUE;
    assign dmi_resp_ready  = state_q == WAIT;
    assign dmi_req_addr    = req_addr_q;
    assign dmi_req_data    = req_data_q;
    assign dmi_req_op      = req_op_q;
    assign busy            = (cf_cnt_q != '0) || (rf_cnt_q != '0) || (state_q != IDLE);

`ifdef DMI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] tcnt_q;
    logic          err_q;
    assign tmo         = state_q == WAIT && !dmi_resp_valid && tcnt_q == TW'(TIMEOUT - 1);
    assign timeout_err = err_q;
    // WAIT-cycle counter restarted on each request handshake; sticky error flag, set beats clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= (state_q == ISSUE && dmi_req_ready) ? '0 : (state_q == WAIT) ? tcnt_q + 1'b1 : tcnt_q;
            err_q  <= tmo || (err_q && !timeout_clr);
        end
`else
    logic unused_clr;
    assign unused_clr  = timeout_clr;
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Command FIFO payload; no reset needed since only entries counted in cf_cnt_q are read
    always_ff @(posedge clk)
        if (cf_push) begin
            cf_addr_q[cf_wp_q] <= host_req_addr;
            cf_data_q[cf_wp_q] <= host_req_data;
            cf_op_q[cf_wp_q]   <= host_req_op;
        end

    // Response FIFO payload; reset so the head outputs read zero out of reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_data_q[i] <= '0;
                rf_resp_q[i] <= '0;
            end
        end else if (rf_push) begin
            rf_data_q[rf_wp_q] <= rf_data_d;
            rf_resp_q[rf_wp_q] <= rf_resp_d;
        end

    // FIFO pointers and occupancy counts, pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cf_wp_q  <= '0;
            cf_rp_q  <= '0;
            rf_wp_q  <= '0;
            rf_rp_q  <= '0;
            cf_cnt_q <= '0;
            rf_cnt_q <= '0;
        end else begin
            cf_wp_q  <= cf_wp_q + AW'(cf_push);
            cf_rp_q  <= cf_rp_q + AW'(cf_pop);
            rf_wp_q  <= rf_wp_q + AW'(rf_push);
            rf_rp_q  <= rf_rp_q + AW'(rf_pop);
            cf_cnt_q <= cf_cnt_q + (AW+1)'(cf_push) - (AW+1)'(cf_pop);
            rf_cnt_q <= rf_cnt_q + (AW+1)'(rf_push) - (AW+1)'(rf_pop);
        end

    // Request fields captured from the CF head when a command is launched
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            req_addr_q <= '0;
            req_data_q <= '0;
            req_op_q   <= '0;
        end else if (state_q == IDLE && state_d == ISSUE) begin
            req_addr_q <= cf_addr_q[cf_rp_q];
            req_data_q <= cf_data_q[cf_rp_q];
            req_op_q   <= cf_op_q[cf_rp_q];
        end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    // Next state, CF pop and RF push; launch needs an RF slot reserved for the reply
    always_comb begin
        state_d   = state_q;
        cf_pop    = 1'b0;
        rf_push   = 1'b0;
        rf_data_d = '0;
        rf_resp_d = 2'b10;
        case (state_q)
            IDLE: if (cf_cnt_q != '0 && rf_cnt_q != FULL) begin
                cf_pop  = 1'b1;
                state_d = (cf_op_q[cf_rp_q] == 2'd3) ? REJ : ISSUE;
            end
            ISSUE: if (dmi_req_ready) state_d = WAIT;
            WAIT: if (dmi_resp_valid) begin
                rf_push   = 1'b1;
                rf_data_d = dmi_resp_data;
                rf_resp_d = dmi_resp_resp;
                state_d   = IDLE;
            end else if (tmo) begin
                rf_push = 1'b1;
                state_d = IDLE;
            end
            REJ: begin
                rf_push = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
